// File: rtl/alu_pkg.sv
// Shared definitions for the ALU component: operation codes, FSM states and
// datapath sizing defaults.
package alu_pkg;

    localparam int ALU_WIDTH  = 16;
    localparam int OP_BITS    = 3;
    localparam int SHIFT_BITS = 4;

    typedef enum logic [OP_BITS-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_SLT = 3'b100,
        OP_SLL = 3'b101,
        OP_SRA = 3'b110,
        OP_MUL = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_MUL_RUN = 2'b01,
        ST_DONE    = 2'b10
    } state_e;

endpackage

// File: rtl/alu_component_if.sv
// Request/response bundle between the operand muxes and the ALU component.
interface alu_component_if
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);

    logic               start;
    logic [OP_BITS-1:0] op;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               busy;
    logic               done;

    modport master (
        output start, op, a, b,
        input  result, zero, overflow, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output result, zero, overflow, busy, done
    );

endinterface

// File: rtl/alu_component_iterative_multiplier.sv
// Signed shift-add multiplier: works on operand magnitudes for MUL_CYCLES
// iterations and restores the sign on the way out.
module iterative_multiplier
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 finished
);

    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic [CW-1:0]      count_reg;
    logic               neg_reg;
    logic               active_reg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // The most negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag = a[WIDTH-1] ? (~a + 1'b1) : a;
    assign b_mag = b[WIDTH-1] ? (~b + 1'b1) : b;

    // product is the post-iteration value, so it is meaningful on the edge where finished=1.
    always_comb begin
        acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
        product  = neg_reg ? (~acc_next + 1'b1) : acc_next;
        finished = active_reg && (count_reg == CW'(MUL_CYCLES - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= 1'b0;
            active_reg <= 1'b0;
        end else if (load) begin
            mcand_reg  <= {{WIDTH{1'b0}}, a_mag};
            mplier_reg <= b_mag;
            acc_reg    <= '0;
            count_reg  <= '0;
            neg_reg    <= a[WIDTH-1] ^ b[WIDTH-1];
            active_reg <= 1'b1;
        end else if (active_reg) begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            count_reg  <= count_reg + 1'b1;
            if (finished) begin
                active_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_component.sv
// ALU with single-cycle logic/arithmetic ops and an iterative signed multiply;
// one request at a time, result announced by a one-cycle done pulse.
module alu_component
    import alu_pkg::*;
#(
    parameter int WIDTH      = ALU_WIDTH,
    parameter int MUL_CYCLES = WIDTH
) (
    input  logic          clock,
    input  logic          reset,
    alu_component_if.slave bus
);

    state_e             state_reg;
    state_e             state_next;
    op_e                op_sel;
    logic               accept;
    logic               mul_load;
    logic               mul_finished;
    logic [2*WIDTH-1:0] mul_product;
    logic [WIDTH:0]     mul_high;
    logic               mul_ovf;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   alu_result;
    logic               alu_ovf;
    logic [WIDTH-1:0]   result_reg;
    logic               zero_reg;
    logic               overflow_reg;

    assign op_sel   = op_e'(bus.op);
    assign accept   = (state_reg == ST_IDLE) && bus.start;
    assign mul_load = accept && (op_sel == OP_MUL);

    iterative_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clock    (clock),
        .reset    (reset),
        .load     (mul_load),
        .a        (bus.a),
        .b        (bus.b),
        .product  (mul_product),
        .finished (mul_finished)
    );

    // Representable in WIDTH signed bits only if the top WIDTH+1 bits are all equal.
    assign mul_high = mul_product[2*WIDTH-1:WIDTH-1];
    assign mul_ovf  = !((&mul_high) || !(|mul_high));

    assign sum  = bus.a + bus.b;
    assign diff = bus.a - bus.b;

    always_comb begin
        alu_result = '0;
        alu_ovf    = 1'b0;
        case (op_sel)
            OP_ADD: begin
                alu_result = sum;
                alu_ovf    = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_result = diff;
                alu_ovf    = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_result = bus.a & bus.b;
            OP_OR:   alu_result = bus.a | bus.b;
            OP_SLT:  alu_result[0] = $signed(bus.a) < $signed(bus.b);
            OP_SLL:  alu_result = bus.a << bus.b[SHIFT_BITS-1:0];
            OP_SRA:  alu_result = $unsigned($signed(bus.a) >>> bus.b[SHIFT_BITS-1:0]);
            default: alu_result = '0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = (op_sel == OP_MUL) ? ST_MUL_RUN : ST_DONE;
                end
            end
            ST_MUL_RUN: begin
                if (mul_finished) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            result_reg   <= '0;
            zero_reg     <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept && (op_sel != OP_MUL)) begin
                result_reg   <= alu_result;
                zero_reg     <= (alu_result == '0);
                overflow_reg <= alu_ovf;
            end else if ((state_reg == ST_MUL_RUN) && mul_finished) begin
                result_reg   <= mul_product[WIDTH-1:0];
                zero_reg     <= (mul_product[WIDTH-1:0] == '0);
                overflow_reg <= mul_ovf;
            end
        end
    end

    assign bus.result   = result_reg;
    assign bus.zero     = zero_reg;
    assign bus.overflow = overflow_reg;
    assign bus.busy     = (state_reg == ST_MUL_RUN);
    assign bus.done     = (state_reg == ST_DONE);

endmodule
